cpu_trace_capture: RTL
======================

Name: cpu_trace_capture

Overview:
- Synthesizable, parametrised trace recorder that watches the single-cycle MIPS core's retire/writeback signals (PC, instruction, RegWr, RD, WData).
- Captures them into a circular buffer, with pre- and post-trigger windows.
- Replaces per-cycle register dumps: trigger on a PC match, a register write or an external strobe, then read back the frozen window, oldest entry first, through a request/valid port.
- Instantiated beside the core in simulation and FPGA builds.

Parameters:
DEPTH, 64, buffer entries; power of two, >= 4.
ADDR_W, 32, PC width.
DATA_W, 32, writeback data width.
POST_CNT, 16, samples captured after the trigger sample; 0 <= POST_CNT <= DEPTH-1.

Ports:
Clk  in  1  clock, all logic on rising edge.
Reset  in  1  synchronous, active-high reset.
Arm  in  1  start/restart capture (single-cycle pulse).
TrigMode  in  2  00 external Trig_in, 01 PC == TrigPC, 10 RegWr && RD == TrigRd, 11 immediate.
Trig_in  in  1  external trigger strobe.
TrigPC  in  ADDR_W  PC match value.
TrigRd  in  5  register-number match value.
Cap_en  in  1  sample valid this cycle (low on stall).
PC  in  ADDR_W  retiring PC.
Instr  in  32  retiring instruction.
RegWr  in  1  writeback enable.
RD  in  5  writeback register.
WData  in  DATA_W  writeback data.
Rd_req  in  1  request the next entry.
Rd_valid  out  1  Rd_data valid this cycle.
Rd_data  out  ADDR_W+DATA_W+38  entry, packed as {PC, Instr, RegWr, RD, WData}.
Rd_last  out  1  with Rd_valid: this is the final stored entry.
State  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE.
Count  out  clog2(DEPTH)+1  valid entries stored, saturating at DEPTH.
Triggered  out  1  trigger has occurred in the current run.

Behaviour:
- Reset (synchronous, overrides everything in that cycle):
  - State=IDLE; wr_ptr, rd_ptr, post counter, Count = 0.
  - Rd_valid, Rd_last, Triggered = 0; Rd_data = 0.
  - Buffer RAM is not cleared.
- Arm (any state) moves to ARMED next cycle: wr_ptr=0, Count=0, Triggered=0, post counter=POST_CNT, any read sequence aborted. Arm has priority over Rd_req and over the trigger in the same cycle.
- IDLE: nothing captured; Rd_req ignored.
- ARMED, each cycle with Cap_en=1:
  - Write the entry at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH; Count = min(Count+1, DEPTH).
  - Evaluate the trigger on that same sample. Trig_in is sampled only when Cap_en=1; mode 11 fires on the first captured sample.
  - On trigger, the triggering sample is stored and Triggered=1 from the next cycle.
  - Next state: POST if POST_CNT>0, else DONE.
- Cap_en=0: no write, no pointer or counter change, no trigger evaluation.
- POST:
  - Each Cap_en=1 sample is written (same pointer and Count rules) and the post counter decrements.
  - The write that takes the counter to 0 moves to DONE next cycle.
  - Further triggers are ignored.
  - The oldest entries are overwritten once full.
- DONE:
  - Capture frozen.
  - On entry, rd_ptr = oldest = (wr_ptr - Count) mod DEPTH, remaining = Count.
  - Rd_req=1 with remaining>0: the next cycle Rd_valid=1 and Rd_data = entry[rd_ptr]; rd_ptr advances and remaining decrements. Read latency is exactly 1 cycle.
  - Rd_last=1 with the entry read when remaining was 1.
  - Back-to-back Rd_req gives one entry per cycle.
  - Rd_req with remaining=0 is ignored (Rd_valid=0).
  - Count is not altered by readout.
- Rd_valid is held for exactly one cycle per accepted request. Rd_data holds its last value when Rd_valid=0.
- Rd_req outside DONE is ignored.

Test Plan:
- Reset: drive Reset=1 for 2 cycles mid-stream -> State=00, Count=0, Rd_valid=0, Triggered=0 on the cycle after the first reset edge.
- DEPTH=8, POST_CNT=3, TrigMode=01, TrigPC=0x10, PC=0,4,8,... with Cap_en=1:
  - Trigger fires on sample 0x10; capture ends after 0x1C; State=DONE, Count=8.
  - 8 Rd_req pulses -> PCs 0x00..0x1C in order; Rd_last only on 0x1C.
  - A 9th Rd_req gives Rd_valid=0.
- Wrap, same config, TrigPC=0x40 -> buffer holds PCs 0x30..0x4C; first read=0x30, last read=0x4C, Count=8.
- TrigMode=10, TrigRd=5, sample 2 carries RegWr=1, RD=5, WData=0xDEADBEEF -> Triggered=1, Count=6 at DONE; the third entry read has RegWr=1, RD=5, WData=0xDEADBEEF.
- Cap_en toggling 1,0,0,1 during POST -> only Cap_en=1 cycles are stored; no duplicate entries; the post counter decrements only on those cycles.
- Arm during POST -> next cycle State=ARMED, Count=0, Triggered=0.
- Arm together with Rd_req in DONE -> Rd_valid=0 next cycle, State=ARMED.

Source files
------------

// File: rtl/cpu_trace_capture_if.sv
// Readout port of the trace recorder: request in, one entry per accepted request out.
interface cpu_trace_capture_if #(
    parameter int ENTRY_W = 102
);
    logic               Rd_req;
    logic               Rd_valid;
    logic [ENTRY_W-1:0] Rd_data;
    logic               Rd_last;

    modport master (output Rd_req, input Rd_valid, Rd_data, Rd_last);
    modport slave  (input Rd_req, output Rd_valid, Rd_data, Rd_last);
endinterface

// File: rtl/cpu_trace_capture.sv
// Retire-stream trace recorder: circular capture with pre/post trigger windows,
// frozen window read back oldest-first through the readout interface.
//
// state | meaning
// IDLE  | nothing captured, reads ignored
// ARMED | capturing pre-trigger history, trigger evaluated per sample
// POST  | capturing POST_CNT samples after the trigger
// DONE  | capture frozen, window available for readout
module cpu_trace_capture #(
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int POST_CNT = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Arm,
    input  logic [1:0]             TrigMode,
    input  logic                   Trig_in,
    input  logic [ADDR_W-1:0]      TrigPC,
    input  logic [4:0]             TrigRd,
    input  logic                   Cap_en,
    input  logic [ADDR_W-1:0]      PC,
    input  logic [31:0]            Instr,
    input  logic                   RegWr,
    input  logic [4:0]             RD,
    input  logic [DATA_W-1:0]      WData,
    cpu_trace_capture_if.slave     rd_port,
    output logic [1:0]             State,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Triggered
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W + 38;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] POST_INIT = CW'(POST_CNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt, oldest;
    logic [CW-1:0]      count, count_inc, post_cnt, remaining;
    logic               triggered, rd_valid, rd_last;
    logic [ENTRY_W-1:0] rd_data;
    logic               trig_hit, do_write, fire, post_dec, rd_accept;

    always_comb begin
        case (TrigMode)
            2'b00:   trig_hit = Trig_in;
            2'b01:   trig_hit = (PC == TrigPC);
            2'b10:   trig_hit = RegWr && (RD == TrigRd);
            default: trig_hit = 1'b1;
        endcase
    end

    assign wr_ptr_nxt = wr_ptr + AW'(1);
    assign count_inc  = (count == DEPTH_C) ? count : count + CW'(1);
    // A full buffer gives count_inc low bits of zero, so oldest lands on wr_ptr_nxt.
    assign oldest     = wr_ptr_nxt - count_inc[AW-1:0];

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        fire      = 1'b0;
        post_dec  = 1'b0;
        rd_accept = 1'b0;
        if (Arm) begin
            state_nxt = S_ARMED;
        end else begin
            case (state)
                S_ARMED: if (Cap_en) begin
                    do_write = 1'b1;
                    if (trig_hit) begin
                        fire      = 1'b1;
                        state_nxt = (POST_CNT > 0) ? S_POST : S_DONE;
                    end
                end
                S_POST: if (Cap_en) begin
                    do_write = 1'b1;
                    post_dec = 1'b1;
                    if (post_cnt == CW'(1)) state_nxt = S_DONE;
                end
                S_DONE:  rd_accept = rd_port.Rd_req && (remaining != '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && do_write) mem[wr_ptr] <= {PC, Instr, RegWr, RD, WData};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            remaining <= '0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else if (Arm) begin
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= POST_INIT;
            remaining <= '0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            rd_last  <= rd_accept && (remaining == CW'(1));
            if (do_write) begin
                wr_ptr <= wr_ptr_nxt;
                count  <= count_inc;
            end
            if (fire)     triggered <= 1'b1;
            if (post_dec) post_cnt  <= post_cnt - CW'(1);
            // Entry into DONE always coincides with a write, so the post-write values apply.
            if (state != S_DONE && state_nxt == S_DONE) begin
                rd_ptr    <= oldest;
                remaining <= count_inc;
            end
            if (rd_accept) begin
                rd_data   <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
                remaining <= remaining - CW'(1);
            end
        end
    end

    assign State            = state;
    assign Count            = count;
    assign Triggered        = triggered;
    assign rd_port.Rd_valid = rd_valid;
    assign rd_port.Rd_last  = rd_last;
    assign rd_port.Rd_data  = rd_data;
endmodule
